// File: rtl/mem_pkg.sv
// Shared types and default constants for the shared memory responder.
// The MEM_ADDR_CHECK_EN build option changes only shared_mem_responder, not this package.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_CYCLES = 2;

  // Operation and write data latched when a request is accepted.
  typedef struct packed {
    op_t         op;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/mem_array.sv
// Word storage for the responder: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/shared_mem_responder.sv
// Wait-state memory responder: IDLE -> BUSY (WAIT_CYCLES+1) -> DONE (1 cycle).
// Build option MEM_ADDR_CHECK_EN rejects misaligned / out-of-range addresses via mem_err.
module shared_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lerMem,
  input  logic        escMem,
  input  logic [31:0] address,
  input  logic [31:0] dadoW,
  output logic [31:0] out,
  output logic        mem_ready,
  output logic        mem_done,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          req_ld;
  logic          acc_fire;
  logic          acc_ok;
  req_t          req_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   rd_data;
  logic          mem_we;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ld    = 1'b0;
    acc_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (escMem || lerMem) begin
          req_ld    = 1'b1;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          acc_fire  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      out   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (acc_fire && req_q.op == OP_READ && acc_ok) out <= rd_data;
    end
  end

  // Transaction latches only load in IDLE, so bus changes later are invisible.
  always_ff @(posedge clock) begin
    if (!reset && req_ld) begin
      req_q.op   <= escMem ? OP_WRITE : OP_READ;
      req_q.data <= dadoW;
      idx_q      <= address[AW+1:2];
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  logic bad_q;
  logic err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (req_ld) bad_q <= (|address[1:0]) || (|address[31:AW+2]);
      if (acc_fire) err_q <= bad_q;
    end
  end

  assign acc_ok  = !bad_q;
  assign mem_err = err_q && (state == DONE);
`else
  // Out-of-range bits simply wrap; sink them so they are visibly intentional.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};
  assign acc_ok  = 1'b1;
  assign mem_err = 1'b0;
`endif

  // Reset must beat a completing write on the same edge.
  assign mem_we    = acc_fire && (req_q.op == OP_WRITE) && acc_ok && !reset;
  assign mem_ready = (state == IDLE);
  assign mem_done  = (state == DONE);

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (req_q.data),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed + random bench for shared_mem_responder (DEPTH=256, WAIT_CYCLES=2, default build).
module tb_shared_mem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        lerMem, escMem;
  logic [31:0] address, dadoW;
  logic [31:0] out;
  logic        mem_ready, mem_done, mem_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] out_m;

  shared_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .lerMem    (lerMem),
    .escMem    (escMem),
    .address   (address),
    .dadoW     (dadoW),
    .out       (out),
    .mem_ready (mem_ready),
    .mem_done  (mem_done),
    .mem_err   (mem_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // One full transaction with cycle-exact checks; junk drives a competing
  // write to 0x30 throughout BUSY/DONE that must be ignored.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input bit junk);
    @(negedge clock);
    chk("ready_idle", {31'd0, mem_ready}, 32'd1);
    chk("done_idle", {31'd0, mem_done}, 32'd0);
    lerMem = rd; escMem = wr; address = a; dadoW = d;
    for (int k = 0; k <= W; k++) begin
      @(negedge clock);
      if (k == 0) begin
        if (junk) begin
          lerMem = 1'b1; escMem = 1'b1; address = 32'h30; dadoW = 32'h55;
        end else begin
          lerMem = 1'b0; escMem = 1'b0; address = $urandom; dadoW = $urandom;
        end
      end
      chk("done_early", {31'd0, mem_done}, 32'd0);
      chk("ready_busy", {31'd0, mem_ready}, 32'd0);
    end
    @(negedge clock);
    if (wr) mem_m[widx(a)] = d;
    else if (rd) out_m = mem_m[widx(a)];
    chk("done_pulse", {31'd0, mem_done}, 32'd1);
    chk("err_done", {31'd0, mem_err}, 32'd0);
    chk("ready_done", {31'd0, mem_ready}, 32'd0);
    chk("out", out, out_m);
    lerMem = 1'b0; escMem = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lerMem = 1'b0; escMem = 1'b0; address = '0; dadoW = '0;
    out_m = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out", out, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    reset = 1'b0;

    // Give every word a known value; memory is never reset.
    for (int i = 0; i < DEPTH; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // Write then read back.
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("wr_rd_0x10", out, 32'hDEADBEEF);

    // Simultaneous read+write: write wins, out untouched.
    txn(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    chk("simul_out_kept", out, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("simul_rd", out, 32'h12345678);

    // Competing request during BUSY/DONE is ignored.
    txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    txn(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

    // Reset mid-operation: sampled at edge 2 of a write to 0x40.
    @(negedge clock);
    escMem = 1'b1; address = 32'h40; dadoW = 32'hBAD0BAD0;
    @(negedge clock);
    escMem = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    out_m = 32'd0;
    chk("midrst_ready", {31'd0, mem_ready}, 32'd1);
    chk("midrst_out", out, 32'd0);
    chk("midrst_done", {31'd0, mem_done}, 32'd0);
    @(negedge clock);
    chk("midrst_no_done", {31'd0, mem_done}, 32'd0);
    txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

    // Wrap and ignored low address bits.
    txn(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
    chk("wrap_word0", out, mem_m[0]);
    txn(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("lowbits_word4", out, mem_m[4]);

    // Read-after-write on the last word.
    txn(1'b0, 1'b1, 32'h3FC, 32'hA5A5F00D, 1'b0);
    txn(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
    chk("raw_last", out, 32'hA5A5F00D);

    // Random traffic, full 32-bit addresses wrap onto the array.
    for (int n = 0; n < 150; n++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      txn(sel[0] | (sel == 2'd0), sel[1], $urandom, $urandom, 1'(n % 7 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
